adc_spi_resp: RTL

Synthesizable SPI responder that stands in for the 8-channel, 12-bit ADC on the e-bike A2D SPI bus.
- Sits at the far end of the bus from the A2D interface master.
- Accepts a 16-bit channel command on MOSI.
- Returns the 12-bit sample of the previously commanded channel on MISO in the next frame.
- Used for FPGA bring-up without the ADC part, and as a cycle-accurate target for full-chip sims.

---
 rtl/adc_spi_resp.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/adc_spi_resp.sv
// adc_spi_resp
//
// SPI responder standing in for the 8-channel, 12-bit ADC on the e-bike A2D bus.
// Each frame the master shifts a 16-bit command in on MOSI. In the same frame,
// the responder shifts out the 12-bit sample of the channel chosen by the
// previous valid command. The sample is zero-extended to 16 bits and sent MSB
// first. All SPI pins are asynchronous to clk. They are synchronized and
// edge-detected before use.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   SS_n       slave select, active low (asynchronous)
//   SCLK       serial clock, idles high (asynchronous)
//   MOSI       command bits from the master, MSB first
//   MISO       response bits, MSB first; high-Z outside a frame
//   chnl_data  packed channel samples, channel n on [12n+11:12n]
//   cmd_vld    one-cycle pulse when a complete 16-bit command is decoded
//   cmd_chnl   channel selected by the last valid command

module adc_spi_resp #(
    parameter int NUM_CH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   SS_n,
    input  logic                   SCLK,
    input  logic                   MOSI,
    output logic                   MISO,
    input  logic [12*NUM_CH-1:0]   chnl_data,
    output logic                   cmd_vld,
    output logic [2:0]             cmd_chnl
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FRAME  = 2'd1,
        DECODE = 2'd2
    } state_t;

    state_t      state_q;
    logic [2:0]  ss_q;
    logic [2:0]  sclk_q;
    logic [1:0]  mosi_q;
    logic [15:0] tx_shft_q;
    logic [14:0] rx_shft_q;
    logic [4:0]  bit_cnt_q;
    logic [2:0]  cmd_chnl_q;
    logic        cmd_vld_q;
    logic [11:0] sel_sample;

    logic ss_fall;
    logic ss_rise;
    logic sclk_rise;
    logic sclk_fall;

    // Two synchronizer stages per pin, plus a third stage for SS_n and SCLK
    // edge detection.
    // SS_n's chain resets low rather than high. If SS_n is already low when
    // reset releases, no fall is ever seen, so the frame in progress is ignored.
    // If SS_n is high, the chain sees a rise while IDLE, which is harmless.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_q   <= 3'b000;
            sclk_q <= 3'b111;
            mosi_q <= 2'b00;
        end else begin
            ss_q   <= {ss_q[1:0], SS_n};
            sclk_q <= {sclk_q[1:0], SCLK};
            mosi_q <= {mosi_q[0], MOSI};
        end
    end

    assign ss_fall   = ~ss_q[1] &  ss_q[2];
    assign ss_rise   =  ss_q[1] & ~ss_q[2];
    assign sclk_rise =  sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] &  sclk_q[2];

    // Sample of the currently latched channel, captured into tx_shft at frame start.
    always_comb begin
        sel_sample = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cmd_chnl_q == i[2:0]) begin
                sel_sample = chnl_data[12*i +: 12];
            end
        end
    end

    // Frame state machine and shift datapath.
    // rx_shft keeps only 15 bits: command bit 15 is a don't-care and simply
    // falls off the top. Command bits 13:11 still land in rx_shft[13:11].
    // An SS_n rise takes priority over any SCLK edge in the same cycle.
    // bit_cnt counts SCLK rises, so a nonzero value means a rise has been
    // seen. The first SCLK fall of a frame therefore does not shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tx_shft_q  <= '0;
            rx_shft_q  <= '0;
            bit_cnt_q  <= '0;
            cmd_chnl_q <= 3'd0;
            cmd_vld_q  <= 1'b0;
        end else begin
            cmd_vld_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ss_fall) begin
                        state_q   <= FRAME;
                        tx_shft_q <= {4'b0000, sel_sample};
                        rx_shft_q <= '0;
                        bit_cnt_q <= '0;
                    end
                end
                FRAME: begin
                    if (ss_rise) begin
                        state_q <= DECODE;
                    end else begin
                        if (sclk_rise) begin
                            rx_shft_q <= {rx_shft_q[13:0], mosi_q[1]};
                            if (bit_cnt_q != 5'd31) begin
                                bit_cnt_q <= bit_cnt_q + 5'd1;
                            end
                        end
                        if (sclk_fall && (bit_cnt_q != 5'd0)) begin
                            tx_shft_q <= {tx_shft_q[14:0], 1'b0};
                        end
                    end
                end
                DECODE: begin
                    if (bit_cnt_q == 5'd16) begin
                        cmd_chnl_q <= rx_shft_q[13:11];
                        cmd_vld_q  <= 1'b1;
                    end
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign MISO     = (state_q == FRAME) ? tx_shft_q[15] : 1'bz;
    assign cmd_vld  = cmd_vld_q;
    assign cmd_chnl = cmd_chnl_q;

endmodule
